// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory between the fetch port and the data port.
// Data wins by default; a saturating starvation counter forces fetch progress.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        i_flush,
    output logic [15:0] i_rdata,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic [15:0] m_addr,
    output logic [15:0] m_datain,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_dataout,
    input  logic        m_done,
    input  logic        m_err,
    output logic        err
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t      r_state;
    logic [2:0]  r_starve_cnt;
    logic        r_drop_i;
    logic        r_err_q;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic        w_d_req;
    logic        w_i_ok;
    logic        w_idle;
    logic        w_force_i;
    logic        w_grant_i;
    logic        w_grant_d;
    logic [2:0]  w_starve_inc;

    // Issue is gated by rst_n so nothing reaches the memory while reset is held.
    assign w_d_req      = d_rd | d_wr;
    assign w_i_ok       = i_req & ~i_flush;
    assign w_idle       = rst_n & (r_state == IDLE);
    assign w_force_i    = w_d_req & w_i_ok & (r_starve_cnt >= LIMIT);
    assign w_grant_i    = w_idle & w_i_ok & (~w_d_req | w_force_i);
    assign w_grant_d    = w_idle & w_d_req & ~w_force_i;
    assign w_starve_inc = ~w_i_ok ? 3'd0 :
                          (r_starve_cnt == 3'd7) ? 3'd7 : r_starve_cnt + 3'd1;
    assign err          = r_err_q;

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        m_rd     = w_grant_i | (w_grant_d & d_rd);
        m_wr     = w_grant_d & d_wr & ~d_rd;
        m_addr   = '0;
        m_datain = '0;
        if (w_grant_i) begin
            m_addr = i_addr;
        end else if (w_grant_d) begin
            m_addr   = d_addr;
            m_datain = d_wdata;
        end else if (r_state != IDLE) begin
            m_addr   = r_addr;
            m_datain = r_wdata;
        end
        i_done  = (r_state == I_BUSY) & m_done & ~r_drop_i & ~i_flush;
        d_done  = (r_state == D_BUSY) & m_done;
        i_rdata = i_done ? m_dataout : '0;
        d_rdata = d_done ? m_dataout : '0;
        i_stall = i_req & ~i_done & ~i_flush;
        d_stall = w_d_req & ~d_done;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_drop_i     <= 1'b0;
            r_err_q      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_state      <= I_BUSY;
                        r_starve_cnt <= '0;
                        r_addr       <= i_addr;
                        r_wdata      <= '0;
                    end else if (w_grant_d) begin
                        r_state      <= D_BUSY;
                        r_starve_cnt <= w_starve_inc;
                        r_addr       <= d_addr;
                        r_wdata      <= d_wdata;
                    end
                    if (d_rd & d_wr) r_err_q <= 1'b1;
                end
                I_BUSY: begin
                    if (m_err) r_err_q <= 1'b1;
                    if (m_done) begin
                        r_state  <= IDLE;
                        r_drop_i <= 1'b0;
                    end else if (i_flush) begin
                        r_drop_i <= 1'b1;
                    end
                end
                D_BUSY: begin
                    if (m_err) r_err_q <= 1'b1;
                    if (m_done) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: each test pushes the transactions it expects, the memory
// responder pops them at issue and checks addresses, strobes and completions.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_flush, i_done, i_stall;
    logic [15:0] i_addr, i_rdata;
    logic        d_rd, d_wr, d_done, d_stall;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic [15:0] m_addr, m_datain, m_dataout;
    logic        m_rd, m_wr, m_done, m_err, err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_i;
        logic        is_wr;
        logic        dropped;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .m_addr(m_addr), .m_datain(m_datain), .m_rd(m_rd), .m_wr(m_wr),
        .m_dataout(m_dataout), .m_done(m_done), .m_err(m_err), .err(err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic is_i, input logic is_wr, input logic dropped,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] rdata);
        exp_t e;
        e.is_i = is_i; e.is_wr = is_wr; e.dropped = dropped;
        e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        return e;
    endfunction

    // Memory responder: waits for an issue, checks it, answers after lat busy cycles.
    task automatic serve(input int lat, input bit keep, input bit flush_busy, input bit merr);
        exp_t        e;
        bit          got;
        logic [15:0] sv_addr, sv_wdata;
        logic        exp_id, exp_dd;
        got = 0;
        #1;
        for (int c = 0; c < 20 && !got; c++) begin
            if (m_rd | m_wr) got = 1;
            else begin @(negedge clk); #1; end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL issue_timeout got=none required=issue");
            return;
        end
        e = sb.pop_front();
        total++;
        if (m_addr !== e.addr) begin bad++; $display("FAIL issue_addr got=%h required=%h", m_addr, e.addr); end
        total++;
        if ({m_rd, m_wr} !== {~e.is_wr, e.is_wr}) begin
            bad++; $display("FAIL issue_strobes got=%b%b required=%b%b", m_rd, m_wr, ~e.is_wr, e.is_wr);
        end
        if (e.is_wr) begin
            total++;
            if (m_datain !== e.wdata) begin bad++; $display("FAIL issue_datain got=%h required=%h", m_datain, e.wdata); end
        end
        sv_addr  = e.is_i ? i_addr : d_addr;
        sv_wdata = d_wdata;
        @(negedge clk);
        if (e.is_i) i_addr = 16'hDEAD;
        else begin d_addr = 16'hDEAD; d_wdata = 16'hBEAD; end
        #1;
        total++;
        if ({m_rd, m_wr} !== 2'b00) begin bad++; $display("FAIL busy_strobes got=%b%b required=00", m_rd, m_wr); end
        total++;
        if (m_addr !== e.addr) begin bad++; $display("FAIL busy_addr got=%h required=%h", m_addr, e.addr); end
        if (e.is_wr) begin
            total++;
            if (m_datain !== e.wdata) begin bad++; $display("FAIL busy_datain got=%h required=%h", m_datain, e.wdata); end
        end
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin @(negedge clk); i_flush = 1'b0; #1; end
            if (k == 1 && flush_busy) begin
                i_flush = 1'b1; i_req = 1'b0; #1;
                total++;
                if (i_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b required=0", i_stall); end
            end
            if (k == lat) begin
                m_done = 1'b1; m_err = merr; m_dataout = e.rdata; #1;
                exp_id = e.is_i & ~e.dropped;
                exp_dd = ~e.is_i;
                total++;
                if ({i_done, d_done} !== {exp_id, exp_dd}) begin
                    bad++; $display("FAIL done_pulse got=%b%b required=%b%b", i_done, d_done, exp_id, exp_dd);
                end
                total++;
                if (i_rdata !== (exp_id ? e.rdata : 16'h0)) begin
                    bad++; $display("FAIL i_rdata got=%h required=%h", i_rdata, exp_id ? e.rdata : 16'h0);
                end
                total++;
                if (d_rdata !== (exp_dd ? e.rdata : 16'h0)) begin
                    bad++; $display("FAIL d_rdata got=%h required=%h", d_rdata, exp_dd ? e.rdata : 16'h0);
                end
                if (exp_dd) begin
                    total++;
                    if (d_stall !== 1'b0) begin bad++; $display("FAIL d_stall_done got=%b required=0", d_stall); end
                end
            end
        end
        if (e.is_i) i_addr = sv_addr;
        else begin d_addr = sv_addr; d_wdata = sv_wdata; end
        if (!keep) begin
            if (e.is_i) i_req = 1'b0;
            else begin d_rd = 1'b0; d_wr = 1'b0; end
        end
        @(negedge clk);
        m_done = 1'b0; m_err = 1'b0; m_dataout = '0; i_flush = 1'b0;
        #1;
        total++;
        if ({i_done, d_done} !== 2'b00) begin bad++; $display("FAIL done_once got=%b%b required=00", i_done, d_done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b1; i_addr = 16'h0100; #2;
        total++;
        if ({m_rd, i_done, err} !== 3'b000) begin
            bad++; $display("FAIL reset_outputs got=%b%b%b required=000", m_rd, i_done, err);
        end
        total++;
        if (m_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h required=0000", m_addr); end
        total++;
        if (i_stall !== 1'b1) begin bad++; $display("FAIL reset_i_stall got=%b required=1", i_stall); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(1, 0, 0, 16'h0100, 16'h0, 16'hC0DE));
        serve(1, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        i_req = 1'b1; i_addr = 16'h0040; d_rd = 1'b1; d_addr = 16'h1000; #1;
        total++;
        if ({i_stall, d_stall} !== 2'b11) begin bad++; $display("FAIL sim_stalls got=%b%b required=11", i_stall, d_stall); end
        sb.push_back(mk(0, 0, 0, 16'h1000, 16'h0, 16'hBEEF));
        sb.push_back(mk(1, 0, 0, 16'h0040, 16'h0, 16'h4321));
        serve(2, 0, 0, 0);
        serve(1, 0, 0, 0);
    endtask

    task automatic test_starvation();
        d_rd = 1'b1; d_addr = 16'h3000; i_req = 1'b1; i_addr = 16'h0200;
        for (int n = 0; n < 4; n++) sb.push_back(mk(0, 0, 0, 16'h3000, 16'h0, 16'(16'h0A00 + n)));
        sb.push_back(mk(1, 0, 0, 16'h0200, 16'h0, 16'h1111));
        for (int n = 0; n < 4; n++) serve(1, 1, 0, 0);
        serve(1, 0, 0, 0);
        // Counter must restart: data wins the next contest again.
        i_req = 1'b1; i_addr = 16'h0300;
        sb.push_back(mk(0, 0, 0, 16'h3000, 16'h0, 16'h2222));
        sb.push_back(mk(1, 0, 0, 16'h0300, 16'h0, 16'h3333));
        serve(1, 0, 0, 0);
        serve(1, 0, 0, 0);
    endtask

    task automatic test_flush();
        i_req = 1'b1; i_flush = 1'b1; i_addr = 16'h0700; #1;
        total++;
        if ({m_rd, i_stall} !== 2'b00) begin bad++; $display("FAIL idle_flush got=%b%b required=00", m_rd, i_stall); end
        i_req = 1'b0;
        @(negedge clk); i_flush = 1'b0;
        i_req = 1'b1; i_addr = 16'h0010;
        sb.push_back(mk(1, 0, 1, 16'h0010, 16'h0, 16'h1234));
        serve(3, 0, 1, 0);
        i_req = 1'b1; i_addr = 16'h0080;
        sb.push_back(mk(1, 0, 0, 16'h0080, 16'h0, 16'h5678));
        serve(1, 0, 0, 0);
    endtask

    task automatic test_store();
        d_wr = 1'b1; d_addr = 16'h2000; d_wdata = 16'h00FF;
        sb.push_back(mk(0, 1, 0, 16'h2000, 16'h00FF, 16'h0));
        serve(3, 0, 0, 0);
    endtask

    task automatic test_errors();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_clean got=%b required=0", err); end
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h3333;
        sb.push_back(mk(0, 0, 0, 16'h3333, 16'h0, 16'h5555));
        serve(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b required=1", err); end
        d_rd = 1'b1; d_addr = 16'h4444; #1;
        total++;
        if (m_rd !== 1'b1) begin bad++; $display("FAIL pre_reset_issue got=%b required=1", m_rd); end
        @(negedge clk); #3;
        rst_n = 1'b0; m_done = 1'b1; m_dataout = 16'h7777; #1;
        total++;
        if ({err, d_done, m_rd} !== 3'b000) begin
            bad++; $display("FAIL midop_reset got=%b%b%b required=000", err, d_done, m_rd);
        end
        total++;
        if (m_addr !== 16'h0) begin bad++; $display("FAIL midop_reset_addr got=%h required=0000", m_addr); end
        d_rd = 1'b0; m_done = 1'b0; m_dataout = '0;
        @(negedge clk); rst_n = 1'b1; #1;
        total++;
        if ({m_rd, m_wr, d_stall} !== 3'b000) begin
            bad++; $display("FAIL post_reset_idle got=%b%b%b required=000", m_rd, m_wr, d_stall);
        end
        i_req = 1'b1; i_addr = 16'h0500;
        sb.push_back(mk(1, 0, 0, 16'h0500, 16'h0, 16'h0A0A));
        serve(2, 0, 0, 1);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL mem_err got=%b required=1", err); end
    endtask

    initial begin
        i_req = 0; i_addr = '0; i_flush = 0;
        d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        m_dataout = '0; m_done = 0; m_err = 0;
        test_reset();
        test_simultaneous();
        test_starvation();
        test_flush();
        test_store();
        test_errors();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d required=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
